// File: rtl/gate_bank_pkg.sv
// gate_bank_pkg: shared definitions for the gate_bank codebase slice.
//   - 3-bit mode type and the mode-code constants MODE_AND .. MODE_HOLD
//   - gate_eval(): the pure per-channel gate function, including HOLD,
//     which returns the channel's current output unchanged.
package gate_bank_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_AND  = 3'd0;
  localparam mode_t MODE_OR   = 3'd1;
  localparam mode_t MODE_XOR  = 3'd2;
  localparam mode_t MODE_NAND = 3'd3;
  localparam mode_t MODE_NOR  = 3'd4;
  localparam mode_t MODE_XNOR = 3'd5;
  localparam mode_t MODE_PASS = 3'd6;
  localparam mode_t MODE_HOLD = 3'd7;

  function automatic logic gate_eval(mode_t mode, logic a, logic b, logic y_prev);
    logic y;
    case (mode)
      MODE_AND:  y = a & b;
      MODE_OR:   y = a | b;
      MODE_XOR:  y = a ^ b;
      MODE_NAND: y = ~(a & b);
      MODE_NOR:  y = ~(a | b);
      MODE_XNOR: y = ~(a ^ b);
      MODE_PASS: y = a;
      default:   y = y_prev;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_bank_if.sv
// gate_bank_if: bundles the gate data path and the serial configuration port.
//   A, B       gate inputs, bit i belongs to channel i
//   Y          registered gate outputs
//   CFG_SHIFT  shift CFG_DIN into the shadow register
//   CFG_DIN    serial configuration data
//   CFG_LATCH  commit shadow to the active mode register
//   CFG_ERR    sticky flag: last latch had a wrong bit count
// master = stimulus side, slave = gate_bank.
interface gate_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] A;
  logic [CHANNELS-1:0] B;
  logic [CHANNELS-1:0] Y;
  logic                CFG_SHIFT;
  logic                CFG_DIN;
  logic                CFG_LATCH;
  logic                CFG_ERR;

  modport master (
    output A, B, CFG_SHIFT, CFG_DIN, CFG_LATCH,
    input  Y, CFG_ERR
  );

  modport slave (
    input  A, B, CFG_SHIFT, CFG_DIN, CFG_LATCH,
    output Y, CFG_ERR
  );
endinterface

// File: rtl/gate_cfg_shifter.sv
// gate_cfg_shifter: serial configuration loader for gate_bank.
//   clk, rst   clock, synchronous active-high reset
//   cfg_shift  shift cfg_din into bit 0 of the shadow register (shift left)
//   cfg_din    serial data; first bit shifted in ends up as the MSB
//   cfg_latch  commit shadow -> active if exactly 3*CHANNELS bits were shifted
//   modes      active mode vector, channel i uses bits [3i+2:3i]
//   cfg_err    sticky: set by a latch with the wrong count, cleared by a good one
module gate_cfg_shifter
  import gate_bank_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_shift,
  input  logic                  cfg_din,
  input  logic                  cfg_latch,
  output logic [3*CHANNELS-1:0] modes,
  output logic                  cfg_err
);

  localparam int NBITS = 3 * CHANNELS;
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBITS);

  logic [NBITS-1:0] shadow;
  logic [NBITS-1:0] active;
  logic [CNT_W-1:0] bit_cnt;

  // Latch has priority over shift; the count checked is the pre-edge value.
  // The counter saturates so over-long loads still commit the last NBITS bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      bit_cnt <= '0;
      cfg_err <= 1'b0;
    end else if (cfg_latch) begin
      bit_cnt <= '0;
      if (bit_cnt == CNT_FULL) begin
        active  <= shadow;
        cfg_err <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end else if (cfg_shift) begin
      shadow <= {shadow[NBITS-2:0], cfg_din};
      if (bit_cnt != CNT_FULL) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign modes = active;

endmodule

// File: rtl/gate_bank.sv
// gate_bank: CHANNELS independent 2-input gates with registered outputs and a
// run-time selectable function per channel (AND/OR/XOR/NAND/NOR/XNOR/PASS/HOLD).
// After reset every channel is AND, so the default part acts as a clocked 74x08.
//   CLK   sole clock, rising edge
//   RST   synchronous, active-high reset (outputs 0, all modes AND)
//   bus   gate_bank_if slave: A, B, Y, CFG_SHIFT, CFG_DIN, CFG_LATCH, CFG_ERR
// CHANNELS legal range is 1..16.
module gate_bank
  import gate_bank_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  gate_bank_if.slave  bus
);

  logic [3*CHANNELS-1:0] modes;
  logic [CHANNELS-1:0]   y_vec;

  gate_cfg_shifter #(
    .CHANNELS (CHANNELS)
  ) u_cfg (
    .clk       (CLK),
    .rst       (RST),
    .cfg_shift (bus.CFG_SHIFT),
    .cfg_din   (bus.CFG_DIN),
    .cfg_latch (bus.CFG_LATCH),
    .modes     (modes),
    .cfg_err   (bus.CFG_ERR)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    mode_t mode_ch;
    logic  y_p0;

    assign mode_ch = modes[3*i +: 3];

    // Output register: uses the mode as it stands before this edge, so a
    // latch at edge k affects the sample taken at edge k+1.
    always_ff @(posedge CLK) begin
      if (RST) begin
        y_p0 <= 1'b0;
      end else begin
        y_p0 <= gate_eval(mode_ch, bus.A[i], bus.B[i], y_p0);
      end
    end

    assign y_vec[i] = y_p0;
  end

  assign bus.Y = y_vec;

endmodule

// File: tb/tb_gate_bank.sv
module tb_gate_bank;
  import gate_bank_pkg::*;

  localparam int CH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   tests = 0;
  int   fails = 0;

  gate_bank_if #(.CHANNELS(CH)) bus ();

  gate_bank #(.CHANNELS(CH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift the top n bits of w, MSB first.
  task automatic shift_bits(input logic [11:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      bus.CFG_SHIFT = 1'b1;
      bus.CFG_DIN   = w[11-k];
      step();
    end
    bus.CFG_SHIFT = 1'b0;
    bus.CFG_DIN   = 1'b0;
  endtask

  task automatic latch();
    bus.CFG_LATCH = 1'b1;
    step();
    bus.CFG_LATCH = 1'b0;
  endtask

  initial begin
    logic [3:0] a_v, b_v, exp_y;

    bus.A = '0; bus.B = '0;
    bus.CFG_SHIFT = 1'b0; bus.CFG_DIN = 1'b0; bus.CFG_LATCH = 1'b0;

    // Reset state
    RST = 1'b1; bus.A = 4'hF; bus.B = 4'hF;
    step();
    check("rst_y", bus.Y, 4'b0000);
    check("rst_err", bus.CFG_ERR, 1'b0);
    RST = 1'b0;

    // Default AND
    bus.A = 4'b1010; bus.B = 4'b1100;
    step();
    check("default_and", bus.Y, 4'b1000);
    check("default_err", bus.CFG_ERR, 1'b0);

    // Full load: ch3 XOR, ch2 NOR, ch1 PASS, ch0 OR
    bus.A = 4'b0110; bus.B = 4'b0101;
    shift_bits(12'b010_100_110_001, 12);
    check("preload_and", bus.Y, 4'b0100);
    latch();
    check("latch_edge_old_and", bus.Y, 4'b0100);
    check("full_load_err", bus.CFG_ERR, 1'b0);
    step();
    check("full_load_new", bus.Y, 4'b0011);

    // Short load after reset
    RST = 1'b1; step(); RST = 1'b0;
    bus.A = 4'b1010; bus.B = 4'b1100;
    shift_bits(12'b111_111_111_111, 11);
    latch();
    check("short_err", bus.CFG_ERR, 1'b1);
    step();
    check("short_still_and", bus.Y, 4'b1000);
    shift_bits(12'b010_010_010_010, 12);
    check("err_sticky_over_shift", bus.CFG_ERR, 1'b1);
    latch();
    check("good_after_short_err", bus.CFG_ERR, 1'b0);
    step();
    check("all_xor", bus.Y, 4'b0110);

    // Latch+shift collision: commit pre-edge shadow (all OR)
    shift_bits(12'b001_001_001_001, 12);
    bus.CFG_SHIFT = 1'b1; bus.CFG_DIN = 1'b1; bus.CFG_LATCH = 1'b1;
    step();
    bus.CFG_SHIFT = 1'b0; bus.CFG_DIN = 1'b0; bus.CFG_LATCH = 1'b0;
    check("collide_err", bus.CFG_ERR, 1'b0);
    step();
    check("collide_all_or", bus.Y, 4'b1110);
    latch();
    check("collide_cnt_cleared", bus.CFG_ERR, 1'b1);

    // Over-long load: counter saturates, last 12 bits (all XNOR) commit
    shift_bits(12'b111_000_000_000, 3);
    shift_bits(12'b101_101_101_101, 12);
    latch();
    check("overlong_err", bus.CFG_ERR, 1'b0);
    step();
    check("overlong_xnor", bus.Y, 4'b1001);

    // NAND on all channels
    shift_bits(12'b011_011_011_011, 12);
    latch();
    step();
    check("all_nand", bus.Y, 4'b0111);

    // HOLD on ch0 while Y[0]=1, others AND
    bus.A = 4'b1111; bus.B = 4'b1111;
    shift_bits(12'b000_000_000_111, 12);
    check("pre_hold_y", bus.Y, 4'b0000);
    latch();
    check("hold_entry_y", bus.Y, 4'b0000);
    // NAND(1,1)=0 at the latch edge; re-enter HOLD with Y[0]=1 via OR first
    shift_bits(12'b001_001_001_001, 12);
    latch();
    step();
    check("or_before_hold", bus.Y, 4'b1111);
    shift_bits(12'b000_000_000_111, 12);
    latch();
    check("hold_latch_edge", bus.Y, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      a_v = 4'(i * 5 + 3);
      b_v = 4'(i * 3 + 6) ^ {3'b000, i[0]};
      bus.A = a_v; bus.B = b_v;
      step();
      exp_y = {a_v[3:1] & b_v[3:1], 1'b1};
      check($sformatf("hold_cycle%0d", i), bus.Y, exp_y);
    end

    // Reset mid-shift
    bus.A = 4'b1010; bus.B = 4'b1100;
    shift_bits(12'b110_110_110_110, 7);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("midrst_y", bus.Y, 4'b0000);
    check("midrst_err", bus.CFG_ERR, 1'b0);
    step();
    check("midrst_and", bus.Y, 4'b1000);
    shift_bits(12'b110_110_110_110, 5);
    latch();
    check("midrst_short_err", bus.CFG_ERR, 1'b1);
    step();
    check("midrst_still_and", bus.Y, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
